mem_bus_arbiter: RTL and testbench

- Shares the single external memory bus between instruction fetch (IF) and the MEM stage data path. Issues one transaction at a time and generates the pipeline stall.
- Performs byte-lane steering for stores and sign/zero extension for loads, using the ramOp encodings in defines.v.
- Sits between the IF and MEM stages and the SRAM/bus bridge. MEM already suppresses misaligned accesses by forcing ramOp to MEM_NOP.

---
 rtl/mem_bus_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the external memory bus between instruction fetch and the MEM-stage
//   data path. One bus transaction at a time, data side has priority. Steers
//   store bytes onto the lanes and sign/zero-extends loads.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   if_req_i, if_addr_i    fetch request / word-aligned fetch address
//   ramOp_i, ramAddr_i     MEM-stage op and byte address
//   storeData_i            right-justified store data
//   flush_i                pipeline flush; in-flight result is discarded
//   inst_o, inst_valid_o   fetched instruction and its valid
//   load_data_o            extended load result (0 for stores)
//   data_valid_o           MEM-stage access complete
//   bus_err_o              completed access ended in a timeout
//   stall_o                combinational pipeline freeze
//   bus_req_o ... bus_wdata_o, bus_rdata_i, bus_ack_i   memory bus
//
// state | meaning
// IDLE  | no bus transaction, arbitrating
// DATA  | MEM-stage load/store on the bus
// INST  | instruction fetch on the bus
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic [3:0]  ramOp_i,
  input  logic [31:0] ramAddr_i,
  input  logic [31:0] storeData_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] load_data_o,
  output logic        data_valid_o,
  output logic        bus_err_o,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam logic [3:0] MEM_NOP = 4'd0, MEM_LB = 4'd1, MEM_LBU = 4'd2,
                         MEM_LH  = 4'd3, MEM_LHU = 4'd4, MEM_LW = 4'd5,
                         MEM_SB  = 4'd6, MEM_SH  = 4'd7, MEM_SW = 4'd8;

  // Abort at the edge that ends the TIMEOUT-th cycle with bus_req_o high.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, INST} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d, we_q, we_d, drop_q, drop_d;
  logic [3:0]         be_q, be_d, op_q, op_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]        inst_q, inst_d, load_q, load_d;
  logic               iv_q, iv_d, dv_q, dv_d, err_q, err_d;
  logic               data_pend, advance, done, discard;
  logic               unused_if_addr;

  assign unused_if_addr = ^if_addr_i[1:0];

  function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] off);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: lane_be = 4'b0001 << off;
      MEM_LH, MEM_LHU, MEM_SH: lane_be = off[1] ? 4'b1100 : 4'b0011;
      default:                 lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [3:0] op, input logic [31:0] d);
    case (op)
      MEM_SB:  lane_wdata = {4{d[7:0]}};
      MEM_SH:  lane_wdata = {2{d[15:0]}};
      MEM_SW:  lane_wdata = d;
      default: lane_wdata = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] r;
    r = rd >> {off, 3'b000};
    case (op)
      MEM_LB:  load_ext = {{24{r[7]}}, r[7:0]};
      MEM_LBU: load_ext = {24'd0, r[7:0]};
      MEM_LH:  load_ext = {{16{r[15]}}, r[15:0]};
      MEM_LHU: load_ext = {16'd0, r[15:0]};
      MEM_LW:  load_ext = r;
      default: load_ext = 32'd0;
    endcase
  endfunction

  assign data_pend = (ramOp_i != MEM_NOP);
  assign stall_o   = (data_pend & ~dv_q) | (if_req_i & ~iv_q);
  assign advance   = ~stall_o;
  assign done      = bus_ack_i | (cnt_q == CNT_LAST);
  assign discard   = drop_q | flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    off_d   = off_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    load_d  = load_q;
    iv_d    = iv_q;
    dv_d    = dv_q;
    err_d   = err_q;

    if (advance || flush_i) begin
      iv_d  = 1'b0;
      dv_d  = 1'b0;
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (data_pend && !dv_q && !flush_i) begin
          state_d = DATA;
          req_d   = 1'b1;
          we_d    = (ramOp_i == MEM_SB) || (ramOp_i == MEM_SH) || (ramOp_i == MEM_SW);
          be_d    = lane_be(ramOp_i, ramAddr_i[1:0]);
          addr_d  = {ramAddr_i[31:2], 2'b00};
          wdata_d = lane_wdata(ramOp_i, storeData_i);
          op_d    = ramOp_i;
          off_d   = ramAddr_i[1:0];
          cnt_d   = '0;
          drop_d  = 1'b0;
        end else if (if_req_i && !iv_q && !flush_i) begin
          state_d = INST;
          req_d   = 1'b1;
          we_d    = 1'b0;
          be_d    = 4'b1111;
          addr_d  = {if_addr_i[31:2], 2'b00};
          wdata_d = 32'd0;
          op_d    = MEM_NOP;
          off_d   = 2'b00;
          cnt_d   = '0;
          drop_d  = 1'b0;
        end
      end
      DATA, INST: begin
        cnt_d = cnt_q + 1'b1;
        if (flush_i) drop_d = 1'b1;
        if (done) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          addr_d  = 32'd0;
          wdata_d = 32'd0;
          drop_d  = 1'b0;
          if (!discard) begin
            if (state_q == DATA) begin
              dv_d   = 1'b1;
              load_d = bus_ack_i ? load_ext(op_q, off_q, bus_rdata_i) : 32'd0;
            end else begin
              iv_d   = 1'b1;
              inst_d = bus_ack_i ? bus_rdata_i : 32'd0;
            end
            // err stays set until advance so a held timed-out result keeps its flag
            if (!bus_ack_i) err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      op_q    <= MEM_NOP;
      off_q   <= 2'b00;
      drop_q  <= 1'b0;
      inst_q  <= 32'd0;
      load_q  <= 32'd0;
      iv_q    <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      off_q   <= off_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      load_q  <= load_d;
      iv_q    <= iv_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_valid_o = iv_q;
  assign load_data_o  = load_q;
  assign data_valid_o = dv_q;
  assign bus_err_o    = err_q;
  assign bus_req_o    = req_q;
  assign bus_we_o     = we_q;
  assign bus_be_o     = be_q;
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4,
                         LW = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, flush_i, bus_ack_i;
  logic [31:0] if_addr_i, ramAddr_i, storeData_i, bus_rdata_i;
  logic [3:0]  ramOp_i;
  logic [31:0] inst_o, load_data_o, bus_addr_o, bus_wdata_o;
  logic        inst_valid_o, data_valid_o, bus_err_o, stall_o, bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;

  mem_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .ramOp_i(ramOp_i), .ramAddr_i(ramAddr_i), .storeData_i(storeData_i),
    .flush_i(flush_i), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .load_data_o(load_data_o), .data_valid_o(data_valid_o), .bus_err_o(bus_err_o),
    .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } bus_t;
  typedef struct { logic [31:0] data; logic err; } dres_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_inst[$];
  dres_t       exp_data[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each new bus transaction and each newly set valid
  // against the expectation queues filled by the stimulus.
  logic prev_req = 1'b0, prev_iv = 1'b0, prev_dv = 1'b0;
  always @(negedge clk) begin
    if (bus_req_o && !prev_req) begin
      if (exp_bus.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_bus_req: addr %h", bus_addr_o);
      end else begin
        bus_t e;
        e = exp_bus.pop_front();
        check("bus_addr", bus_addr_o, e.addr);
        check("bus_be", {28'd0, bus_be_o}, {28'd0, e.be});
        check("bus_we", {31'd0, bus_we_o}, {31'd0, e.we});
        if (e.we) check("bus_wdata", bus_wdata_o, e.wdata);
      end
    end
    if (inst_valid_o && !prev_iv) begin
      if (exp_inst.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_inst_valid: inst %h", inst_o);
      end else check("inst_o", inst_o, exp_inst.pop_front());
    end
    if (data_valid_o && !prev_dv) begin
      if (exp_data.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_data_valid: data %h", load_data_o);
      end else begin
        dres_t d;
        d = exp_data.pop_front();
        check("load_data_o", load_data_o, d.data);
        check("bus_err_o", {31'd0, bus_err_o}, {31'd0, d.err});
      end
    end
    prev_req = bus_req_o;
    prev_iv  = inst_valid_o;
    prev_dv  = data_valid_o;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!bus_req_o && k < 20) begin
      tick();
      k++;
    end
    check("req_seen", {31'd0, bus_req_o}, 32'd1);
  endtask

  // Called in the first req cycle; acks during the n-th req cycle.
  task automatic ack_at(input int n, input logic [31:0] rdata);
    repeat (n - 1) tick();
    bus_rdata_i = rdata;
    bus_ack_i   = 1'b1;
    tick();
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'd0;
  endtask

  task automatic data_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [3:0] be, input logic we, input logic [31:0] wd,
                         input logic [31:0] rdata, input logic [31:0] ld);
    exp_bus.push_back('{{addr[31:2], 2'b00}, be, we, wd});
    exp_data.push_back('{ld, 1'b0});
    ramOp_i = op; ramAddr_i = addr; storeData_i = sd;
    #1 check("stall_data_pending", {31'd0, stall_o}, 32'd1);
    wait_req();
    ack_at(2, rdata);
    #1;
    check("data_valid_set", {31'd0, data_valid_o}, 32'd1);
    check("stall_after_data", {31'd0, stall_o}, 32'd0);
    tick();
    check("data_valid_cleared", {31'd0, data_valid_o}, 32'd0);
    ramOp_i = NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_req_i = 0; if_addr_i = 0; ramOp_i = NOP; ramAddr_i = 0;
    storeData_i = 0; flush_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
    repeat (3) tick();
    check("rst_outputs", {inst_o | load_data_o | bus_addr_o | bus_wdata_o},
          32'd0);
    check("rst_flags", {25'd0, inst_valid_o, data_valid_o, bus_err_o, stall_o,
          bus_req_o, bus_we_o, |bus_be_o}, 32'd0);
    rst = 1'b0;
    tick();

    // fetch only, ack in 3rd req cycle
    exp_bus.push_back('{32'h8000_0010, 4'hF, 1'b0, 32'd0});
    exp_inst.push_back(32'h2408_0001);
    if_addr_i = 32'h8000_0010; if_req_i = 1'b1;
    #1 check("stall_fetch_pending", {31'd0, stall_o}, 32'd1);
    wait_req();
    ack_at(3, 32'h2408_0001);
    #1;
    check("inst_valid_set", {31'd0, inst_valid_o}, 32'd1);
    check("stall_after_fetch", {31'd0, stall_o}, 32'd0);
    check("req_dropped_on_ack", {31'd0, bus_req_o}, 32'd0);
    tick();
    check("inst_valid_cleared", {31'd0, inst_valid_o}, 32'd0);
    if_req_i = 1'b0;

    // loads and stores: lane steering and extension
    data_op(LB,  32'h103, 32'd0, 4'b1000, 1'b0, 32'd0, 32'h80AA_BBCC, 32'hFFFF_FF80);
    data_op(LBU, 32'h103, 32'd0, 4'b1000, 1'b0, 32'd0, 32'h80AA_BBCC, 32'h0000_0080);
    data_op(LH,  32'h102, 32'd0, 4'b1100, 1'b0, 32'd0, 32'h80AA_BBCC, 32'hFFFF_80AA);
    data_op(LHU, 32'h102, 32'd0, 4'b1100, 1'b0, 32'd0, 32'h80AA_BBCC, 32'h0000_80AA);
    data_op(LB,  32'h100, 32'd0, 4'b0001, 1'b0, 32'd0, 32'h80AA_BB4C, 32'h0000_004C);
    data_op(SH,  32'h202, 32'h1234_ABCD, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'hFFFF_FFFF, 32'd0);
    data_op(SB,  32'h201, 32'h0000_005A, 4'b0010, 1'b1, 32'h5A5A_5A5A, 32'd0, 32'd0);
    data_op(SW,  32'h204, 32'hCAFE_F00D, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'd0, 32'd0);

    // nothing pending: no request; a stray ack is ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_no_req", {31'd0, bus_req_o}, 32'd0);
    end
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
    tick();
    check("idle_ack_ignored", {30'd0, inst_valid_o, data_valid_o}, 32'd0);

    // simultaneous fetch and LW: data first, then fetch
    exp_bus.push_back('{32'h0000_0300, 4'hF, 1'b0, 32'd0});
    exp_bus.push_back('{32'h8000_0020, 4'hF, 1'b0, 32'd0});
    exp_data.push_back('{32'hDEAD_BEEF, 1'b0});
    exp_inst.push_back(32'h0000_0013);
    if_addr_i = 32'h8000_0020; if_req_i = 1'b1; ramOp_i = LW; ramAddr_i = 32'h300;
    wait_req();
    ack_at(1, 32'hDEAD_BEEF);
    #1;
    check("both_stall_after_data", {31'd0, stall_o}, 32'd1);
    check("both_valids_mid", {30'd0, inst_valid_o, data_valid_o}, 32'd1);
    wait_req();
    ack_at(2, 32'h0000_0013);
    #1;
    check("both_stall_low", {31'd0, stall_o}, 32'd0);
    check("both_valids_held", {30'd0, inst_valid_o, data_valid_o}, 32'd3);
    check("both_load_held", load_data_o, 32'hDEAD_BEEF);
    tick();
    check("both_valids_cleared", {30'd0, inst_valid_o, data_valid_o}, 32'd0);
    check("both_stall_one_cycle", {31'd0, stall_o}, 32'd1);
    ramOp_i = NOP; if_req_i = 1'b0;
    tick();

    // timeout on a load
    exp_bus.push_back('{32'h0000_0400, 4'hF, 1'b0, 32'd0});
    exp_data.push_back('{32'd0, 1'b1});
    ramOp_i = LW; ramAddr_i = 32'h400;
    wait_req();
    begin
      int k = 0;
      while (bus_req_o && k < 10) begin
        k++;
        tick();
      end
      check("timeout_req_len", {31'd0, (k >= TO) && (k <= TO + 1)}, 32'd1);
    end
    #1;
    check("timeout_valid", {31'd0, data_valid_o}, 32'd1);
    check("timeout_err", {31'd0, bus_err_o}, 32'd1);
    check("timeout_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("timeout_err_cleared", {31'd0, bus_err_o}, 32'd0);
    ramOp_i = NOP;
    tick();

    // flush during a fetch: result dropped, refetch follows
    exp_bus.push_back('{32'h8000_0040, 4'hF, 1'b0, 32'd0});
    if_addr_i = 32'h8000_0040; if_req_i = 1'b1;
    wait_req();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    if_addr_i = 32'h8000_0180;
    exp_bus.push_back('{32'h8000_0180, 4'hF, 1'b0, 32'd0});
    exp_inst.push_back(32'h2222_2222);
    check("flush_not_aborted", {31'd0, bus_req_o}, 32'd1);
    ack_at(2, 32'h1111_1111);
    #1;
    check("flush_inst_dropped", {31'd0, inst_valid_o}, 32'd0);
    check("flush_req_dropped", {31'd0, bus_req_o}, 32'd0);
    wait_req();
    ack_at(1, 32'h2222_2222);
    #1 check("refetch_valid", {31'd0, inst_valid_o}, 32'd1);
    tick();
    if_req_i = 1'b0;
    tick();

    // reset in the middle of a data access
    exp_bus.push_back('{32'h0000_0500, 4'hF, 1'b0, 32'd0});
    ramOp_i = LW; ramAddr_i = 32'h500;
    wait_req();
    tick();
    rst = 1'b1; ramOp_i = NOP;
    tick();
    check("rst_mid_req", {31'd0, bus_req_o}, 32'd0);
    check("rst_mid_data", inst_o | load_data_o | bus_addr_o | bus_wdata_o, 32'd0);
    check("rst_mid_flags", {26'd0, inst_valid_o, data_valid_o, bus_err_o, stall_o,
          bus_we_o, |bus_be_o}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    check("post_rst_idle", {29'd0, bus_req_o, inst_valid_o, data_valid_o}, 32'd0);

    check("bus_queue_empty", exp_bus.size(), 32'd0);
    check("inst_queue_empty", exp_inst.size(), 32'd0);
    check("data_queue_empty", exp_data.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
